uart_rx_framed: RTL and testbench
=================================

UART_RX_FRAMED -- requirements
Module: uart_rx_framed

Interface
REQ-001 Parameter CLOCK_FREQUENCY, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, line bit rate in baud.
REQ-003 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 Parameter PARITY_ODD, default 0; 0 selects even parity, 1 selects odd parity; used only when UART_RX_PARITY_EN is defined.
REQ-006 clockIN  input  1  single system clock; all logic on its rising edge.
REQ-007 rxResetIN  input  1  synchronous, active-high reset.
REQ-008 rxIN  input  1  asynchronous serial line; idles high.
REQ-009 rxDataOUT  output  DATA_BITS  received word, LSB = first bit received.
REQ-010 rxValidOUT  output  1  rxDataOUT and the error flags hold an unconsumed word.
REQ-011 rxReadyIN  input  1  consumer accepts the word on a cycle where rxValidOUT=1 and rxReadyIN=1.
REQ-012 rxIdleOUT  output  1  high while the receiver FSM is in IDLE.
REQ-013 rxFrameErrOUT  output  1  stop-bit error for the held word.
REQ-014 rxParityErrOUT  output  1  parity error for the held word.
REQ-015 rxOverrunOUT  output  1  sticky flag: one or more words were dropped.

Function
REQ-016 rxIN shall pass through a 2-flop synchroniser before any use.
REQ-017 The block shall generate an internal 16x oversample tick every DIV = CLOCK_FREQUENCY/(BAUD_RATE*16) cycles, using integer truncation; the block shall use no derived clocks.
REQ-018 The tick counter shall reload to phase 0 on the cycle a start edge is detected.
REQ-019 The FSM shall have states IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-020 IDLE -> START on a synchronised high-to-low transition of rxIN.
REQ-021 Each bit value shall be the majority of the synchronised samples taken at oversample ticks 7, 8 and 9 of that bit; the bit is resolved at tick 9.
REQ-022 START: if the resolved start bit is 1, the FSM shall return to IDLE with no output change (false start); otherwise it shall go to DATA.
REQ-023 DATA shall shift in DATA_BITS bits, LSB first, then go to PARITY if parity is enabled, otherwise to STOP.
REQ-024 STOP shall check STOP_BITS stop bits; any stop bit resolved as 0 sets the frame error for the word.
REQ-025 The word shall be delivered 1 clock after the tick-9 resolution of the last stop bit; the FSM shall then go to IDLE, or to BREAK if the frame error is set.
REQ-026 BREAK shall hold until the synchronised rxIN is 1, then go to IDLE; a held-low line shall never produce a second word.
REQ-027 On delivery with rxValidOUT=0, or with rxValidOUT=1 and rxReadyIN=1 in the same cycle, the block shall load data and both error flags and set rxValidOUT=1; rxOverrunOUT shall not change.
REQ-028 On delivery with rxValidOUT=1 and rxReadyIN=0, the block shall drop the new word, keep the held word unchanged and set rxOverrunOUT.
REQ-029 A handshake with no delivery in the same cycle shall clear rxValidOUT and rxOverrunOUT on the next edge.
REQ-030 rxDataOUT, rxFrameErrOUT and rxParityErrOUT shall be stable while rxValidOUT=1 and no handshake occurs.

Reset
REQ-031 While rxResetIN=1 at a clock edge: FSM to IDLE, tick counter to 0, synchroniser flops to 1, rxDataOUT=0, rxValidOUT=0, rxFrameErrOUT=0, rxParityErrOUT=0, rxOverrunOUT=0, rxIdleOUT=1.
REQ-032 Reset asserted mid-frame shall discard the partial frame; after release, the block shall wait for a new falling edge.

Configuration
REQ-033 Macro UART_RX_PARITY_EN defined: one parity bit follows the data bits; the parity check covers data and parity bits (even parity if PARITY_ODD=0, odd parity if PARITY_ODD=1); a mismatch sets the parity error for the word.
REQ-034 Macro UART_RX_PARITY_EN undefined: no PARITY state and no parity logic; rxParityErrOUT is tied to 0 and frames carry no parity bit.

Verification (CLOCK_FREQUENCY=50_000_000, BAUD_RATE=115200, DIV=27, DATA_BITS=8, STOP_BITS=1 unless stated)
REQ-035 Frame 0xA5 sent with rxReadyIN=1 -> rxValidOUT pulses for 1 cycle with rxDataOUT=0xA5, both error flags 0, rxOverrunOUT 0.
REQ-036 Low glitch of 3 bit-periods/16 on an idle line -> false start: no rxValidOUT, rxIdleOUT back to 1 within 1 bit period.
REQ-037 rxReadyIN=0; frames 0x11 then 0x22 -> rxDataOUT stays 0x11 and rxOverrunOUT=1; one handshake then clears both rxValidOUT and rxOverrunOUT.
REQ-038 Frame 0x3C with stop bit 0, then line held low 20 bit periods -> exactly one word with rxFrameErrOUT=1; FSM in BREAK until the line goes high.
REQ-039 UART_RX_PARITY_EN defined, PARITY_ODD=0: 0x07 with parity bit 0 -> rxParityErrOUT=1; 0x07 with parity bit 1 -> rxParityErrOUT=0.
REQ-040 rxResetIN pulsed for 1 cycle after data bit 4 of 0x5A, remaining bits still sent -> no word delivered and all outputs at reset values; the next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_framed.sv
`default_nettype none
// ============================================================================
// uart_rx_framed: 16x-oversampled UART receiver with valid/ready word output.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.   Rev 1.0
// ============================================================================
module uart_rx_framed #(
  parameter int CLOCK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE       = 9600,
  parameter int DATA_BITS       = 8,
  parameter int STOP_BITS       = 1,
  parameter int PARITY_ODD      = 0
) (
  input  logic                 clockIN,
  input  logic                 rxResetIN,
  input  logic                 rxIN,
  output logic [DATA_BITS-1:0] rxDataOUT,
  output logic                 rxValidOUT,
  input  logic                 rxReadyIN,
  output logic                 rxIdleOUT,
  output logic                 rxFrameErrOUT,
  output logic                 rxParityErrOUT,
  output logic                 rxOverrunOUT
);

  localparam int c_div   = CLOCK_FREQUENCY / (BAUD_RATE * 16);
  localparam int c_div_w = (c_div > 1) ? $clog2(c_div) : 1;
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(c_div - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [1:0]           arm_q, arm_d;
  logic [c_div_w-1:0]   div_q, div_d;
  logic [3:0]           os_q, os_d;
  logic [1:0]           vote_q, vote_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 ferr_q, ferr_d;
  logic                 deliver_q, deliver_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q, perr_d;
  logic                 perr_out_q, perr_out_d;
`endif

  logic start_edge, tick, resolve, bit_val;

  always_comb begin
    sync1_d = rxIN;
    sync2_d = sync1_q;
    // The synchroniser reset value of 1 is not a real line sample; only arm the
    // edge detector once both stages hold genuine samples.
    arm_d   = {arm_q[0], 1'b1};
    prev_d  = arm_q[1] & sync2_q;

    start_edge = (state_q == S_IDLE) && prev_q && !sync2_q;
    tick       = (div_q == c_div_last);
    resolve    = tick && (os_q == 4'd9);
    bit_val    = (vote_q[0] & vote_q[1]) | (vote_q[0] & sync2_q) | (vote_q[1] & sync2_q);

    div_d  = tick ? '0 : div_q + 1'b1;
    os_d   = tick ? os_q + 4'd1 : os_q;
    vote_d = vote_q;
    if (tick && os_q == 4'd7) vote_d[0] = sync2_q;
    if (tick && os_q == 4'd8) vote_d[1] = sync2_q;
    if (start_edge) begin
      div_d = '0;
      os_d  = '0;
    end

    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    ferr_d     = ferr_q;
    deliver_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d     = perr_q;
`endif

    case (state_q)
      S_IDLE: if (start_edge) begin
        state_d    = S_START;
        bit_cnt_d  = '0;
        stop_cnt_d = 1'b0;
        ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d     = 1'b0;
`endif
      end
      S_START: if (resolve) state_d = bit_val ? S_IDLE : S_DATA;
      S_DATA: if (resolve) begin
        shreg_d   = {bit_val, shreg_q[DATA_BITS-1:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (resolve) begin
        perr_d  = (^shreg_q) ^ bit_val ^ PARITY_ODD[0];
        state_d = S_STOP;
      end
`endif
      S_STOP: if (resolve) begin
        if (!bit_val) ferr_d = 1'b1;
        if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
          deliver_d = 1'b1;
          state_d   = (ferr_q || !bit_val) ? S_BREAK : S_IDLE;
        end else begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      S_BREAK: if (sync2_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Output holding register: a new word either replaces an accepted one or is dropped.
    dout_d     = dout_q;
    valid_d    = valid_q;
    ferr_out_d = ferr_out_q;
    ovr_d      = ovr_q;
`ifdef UART_RX_PARITY_EN
    perr_out_d = perr_out_q;
`endif
    if (deliver_q) begin
      if (!valid_q || rxReadyIN) begin
        dout_d     = shreg_q;
        valid_d    = 1'b1;
        ferr_out_d = ferr_q;
`ifdef UART_RX_PARITY_EN
        perr_out_d = perr_q;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rxReadyIN) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clockIN) begin
    if (rxResetIN) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b0;
      arm_q      <= '0;
      div_q      <= '0;
      os_q       <= '0;
      vote_q     <= '0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      ferr_q     <= 1'b0;
      deliver_q  <= 1'b0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q     <= 1'b0;
      perr_out_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      arm_q      <= arm_d;
      div_q      <= div_d;
      os_q       <= os_d;
      vote_q     <= vote_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      ferr_q     <= ferr_d;
      deliver_q  <= deliver_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      ferr_out_q <= ferr_out_d;
      ovr_q      <= ovr_d;
`ifdef UART_RX_PARITY_EN
      perr_q     <= perr_d;
      perr_out_q <= perr_out_d;
`endif
    end
  end

  assign rxDataOUT     = dout_q;
  assign rxValidOUT    = valid_q;
  assign rxFrameErrOUT = ferr_out_q;
  assign rxOverrunOUT  = ovr_q;
  assign rxIdleOUT     = (state_q == S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign rxParityErrOUT = perr_out_q;
`else
  // No parity bit on the line; the parameter is referenced only to keep it live.
  assign rxParityErrOUT = PARITY_ODD[0] & 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_framed.sv
`default_nettype none
// tb_uart_rx_framed: directed bench for uart_rx_framed at 50 MHz / 115200 baud (432 clocks per bit).
module tb_uart_rx_framed;
  localparam int BIT_CLKS = 432;

  logic       clk = 1'b0;
  logic       rst, rx, ready;
  logic [7:0] data;
  logic       valid, idle, ferr, perr, ovr;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         acc_cnt = 0;
  int         valid_cycles = 0;
  int         base_acc, base_valid;
  logic [7:0] acc_data = '0;
  logic       acc_ferr = 1'b0;
  logic       acc_perr = 1'b0;
  logic [7:0] pat;

  always #10 clk = ~clk;

  uart_rx_framed #(
    .CLOCK_FREQUENCY(50_000_000),
    .BAUD_RATE      (115200),
    .DATA_BITS      (8),
    .STOP_BITS      (1),
    .PARITY_ODD     (0)
  ) dut (
    .clockIN       (clk),
    .rxResetIN     (rst),
    .rxIN          (rx),
    .rxDataOUT     (data),
    .rxValidOUT    (valid),
    .rxReadyIN     (ready),
    .rxIdleOUT     (idle),
    .rxFrameErrOUT (ferr),
    .rxParityErrOUT(perr),
    .rxOverrunOUT  (ovr)
  );

  // Values seen at the falling edge are those the next rising edge acts on.
  always @(negedge clk) begin
    if (valid === 1'b1) valid_cycles++;
    if (valid === 1'b1 && ready === 1'b1) begin
      acc_cnt++;
      acc_data = data;
      acc_ferr = ferr;
      acc_perr = perr;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    cyc(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop_v);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par_v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par_v);
    send_bit(1'b1);
  endtask
`endif

  initial begin
    rst = 1'b1; rx = 1'b1; ready = 1'b1;
    cyc(4);
    chk("reset_data",  {24'd0, data}, 32'h0);
    chk("reset_valid", {31'd0, valid}, 32'h0);
    chk("reset_idle",  {31'd0, idle}, 32'h1);
    chk("reset_ferr",  {31'd0, ferr}, 32'h0);
    chk("reset_perr",  {31'd0, perr}, 32'h0);
    chk("reset_ovr",   {31'd0, ovr}, 32'h0);
    rst = 1'b0;
    cyc(2 * BIT_CLKS);

    // Clean frame with consumer ready: one-cycle valid pulse.
    base_valid = valid_cycles;
    send_frame(8'hA5, 1'b1);
    cyc(4);
    chk("a5_count",       acc_cnt, 1);
    chk("a5_data",        {24'd0, acc_data}, 32'hA5);
    chk("a5_ferr",        {31'd0, acc_ferr}, 32'h0);
    chk("a5_perr",        {31'd0, acc_perr}, 32'h0);
    chk("a5_valid_cycles", valid_cycles - base_valid, 1);
    chk("a5_ovr",         {31'd0, ovr}, 32'h0);

    // Short low glitch: enters START, then rejects it as a false start.
    base_acc = acc_cnt; base_valid = valid_cycles;
    rx = 1'b0;
    cyc(3 * BIT_CLKS / 16);
    chk("glitch_busy", {31'd0, idle}, 32'h0);
    rx = 1'b1;
    cyc(BIT_CLKS);
    chk("glitch_idle",  {31'd0, idle}, 32'h1);
    chk("glitch_words", acc_cnt - base_acc, 0);
    chk("glitch_valid", valid_cycles - base_valid, 0);

    // Consumer stalled: second word is dropped and overrun latches.
    ready = 1'b0;
    send_frame(8'h11, 1'b1);
    cyc(BIT_CLKS);
    chk("ovr1_valid", {31'd0, valid}, 32'h1);
    chk("ovr1_data",  {24'd0, data}, 32'h11);
    chk("ovr1_ovr",   {31'd0, ovr}, 32'h0);
    send_frame(8'h22, 1'b1);
    cyc(4);
    chk("ovr2_valid", {31'd0, valid}, 32'h1);
    chk("ovr2_data",  {24'd0, data}, 32'h11);
    chk("ovr2_ovr",   {31'd0, ovr}, 32'h1);
    base_acc = acc_cnt;
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    cyc(2);
    chk("hs_valid", {31'd0, valid}, 32'h0);
    chk("hs_ovr",   {31'd0, ovr}, 32'h0);
    chk("hs_data",  {24'd0, acc_data}, 32'h11);
    chk("hs_count", acc_cnt - base_acc, 1);

    // Bad stop bit followed by a held-low line: one word, then BREAK.
    ready = 1'b1;
    cyc(BIT_CLKS);
    base_acc = acc_cnt;
    send_frame(8'h3C, 1'b0);
    cyc(20 * BIT_CLKS);
    chk("brk_count", acc_cnt - base_acc, 1);
    chk("brk_data",  {24'd0, acc_data}, 32'h3C);
    chk("brk_ferr",  {31'd0, acc_ferr}, 32'h1);
    chk("brk_busy",  {31'd0, idle}, 32'h0);
    rx = 1'b1;
    cyc(5);
    chk("brk_idle",  {31'd0, idle}, 32'h1);
    chk("brk_once",  acc_cnt - base_acc, 1);
    cyc(2 * BIT_CLKS);

    // Reset pulse after data bit 4 of 0x5A.
    pat = 8'h5A;
    base_acc = acc_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(pat[i]);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("mid_rst_data",  {24'd0, data}, 32'h0);
    chk("mid_rst_valid", {31'd0, valid}, 32'h0);
    chk("mid_rst_ferr",  {31'd0, ferr}, 32'h0);
    chk("mid_rst_perr",  {31'd0, perr}, 32'h0);
    chk("mid_rst_ovr",   {31'd0, ovr}, 32'h0);
    chk("mid_rst_idle",  {31'd0, idle}, 32'h1);
    for (int i = 5; i < 8; i++) send_bit(pat[i]);
    send_bit(1'b1);
    chk("mid_rst_words", acc_cnt - base_acc, 0);
    // The 1->0 step between data bits 6 and 7 is a genuine start edge; let
    // whatever the receiver resynchronised onto run out on the idle line.
    cyc(12 * BIT_CLKS);
    base_acc = acc_cnt;
    send_frame(8'h5A, 1'b1);
    cyc(4);
    chk("after_rst_count", acc_cnt - base_acc, 1);
    chk("after_rst_data",  {24'd0, acc_data}, 32'h5A);
    chk("after_rst_ferr",  {31'd0, acc_ferr}, 32'h0);

`ifdef UART_RX_PARITY_EN
    cyc(BIT_CLKS);
    send_frame_par(8'h07, 1'b0);
    cyc(4);
    chk("par_bad_data", {24'd0, acc_data}, 32'h07);
    chk("par_bad_perr", {31'd0, acc_perr}, 32'h1);
    send_frame_par(8'h07, 1'b1);
    cyc(4);
    chk("par_good_perr", {31'd0, acc_perr}, 32'h0);
`else
    chk("noparity_perr", {31'd0, perr}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
